axi_fsrc_up_cmd_master: RTL and testbench
=========================================

Name: axi_fsrc_up_cmd_master

Overview:
- Initiator for the up_* register bus (up_wreq/up_wack, up_rreq/up_rack) used by the axi_fsrc regmaps.
- Accepts single-word read/write commands on a valid/ready stream, issues exactly one bus request per command and waits for the matching ack, with a timeout.
- Returns one response per command on a second valid/ready stream.
- Used by on-chip sequencers/test logic to program FSRC regmaps without a CPU; shares the regmap's clock.

Parameters:
- TIMEOUT_CYCLES, 256, ack wait limit in cycles; 0 disables the timeout (waits forever).
- ERR_CNT_WIDTH, 16, width of saturating error counter.

Ports:
- clk  in  1  clock; all up_* signals are in this domain.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  14  word address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_error  out  1  1=timeout.
- up_wreq  out  1  write request pulse.
- up_waddr  out  14  write address.
- up_wdata  out  32  write data.
- up_wack  in  1  write ack.
- up_rreq  out  1  read request pulse.
- up_raddr  out  14  read address.
- up_rdata  in  32  read data, valid with up_rack.
- up_rack  in  1  read ack.
- busy  out  1  state != IDLE.
- stray_ack  out  1  sticky; unexpected ack seen.
- err_count  out  ERR_CNT_WIDTH  saturating timeout count.

Behaviour:
- Reset values: every output is 0, state = IDLE, in-flight command dropped, no response produced for it.
- FSM states: IDLE, REQ, WAIT, RSP.
- IDLE
  - cmd_ready = 1 (combinational from state, 0 while reset is high).
  - On cmd_valid & cmd_ready: latch cmd_write/cmd_addr/cmd_wdata and go to REQ.
- REQ (one cycle)
  - Assert up_wreq (write) or up_rreq (read) for exactly this one cycle.
  - Go to WAIT and clear the wait counter.
- up_waddr/up_wdata/up_raddr
  - Driven from the latched command from REQ through the end of WAIT.
  - 0 in IDLE and RSP.
  - Only the bus of the active type is non-zero.
- WAIT
  - Count cycles.
  - Matching ack (up_wack for a write, up_rack for a read) completes the command and the FSM goes to RSP next cycle:
    - read: capture up_rdata in the ack cycle into rsp_rdata;
    - write: rsp_rdata = 0.
  - An ack in the REQ cycle itself is treated as stray; the earliest legal ack is the first WAIT cycle.
  - Timeout: TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 with no matching ack:
    - go to RSP with rsp_error = 1, rsp_rdata = 0;
    - err_count += 1, saturating at all-ones.
  - Matching ack in the same cycle as the timeout threshold: the ack wins, no error.
- RSP
  - rsp_valid = 1; rsp_* held stable until rsp_ready.
  - Handshake cycle: go to IDLE.
  - cmd_ready stays 0 throughout RSP, so no overlap.
- Latency with a one-cycle-registered responder:
  - cmd handshake at cycle 0;
  - req at cycle 1;
  - ack at cycle 2;
  - rsp_valid at cycle 3.
  - Throughput is one command per 4 cycles when rsp_ready = 1.
- stray_ack
  - Set to 1 on any up_wack/up_rack outside WAIT, or on the non-matching ack type during WAIT.
  - Includes a late ack arriving after a timeout.
  - A stray ack never completes a command.
  - Clears only on reset.
- Simultaneous up_wack & up_rack in WAIT: the matching one completes the command; the other sets stray_ack.
- cmd_* inputs are ignored outside the IDLE handshake.

Test Plan:
- Write addr 0x002 data 0xDEADBEEF, then read 0x002 against a regmap responder:
  - write: up_wreq high exactly 1 cycle with up_waddr=0x002, up_wdata=0xDEADBEEF; rsp_valid at cycle 3 with rsp_write=1, rsp_error=0.
  - read: rsp_rdata=0xDEADBEEF.
- Read 0x003 with the responder returning 0x46535243 on rack → rsp_rdata=0x46535243, err_count=0, stray_ack=0.
- TIMEOUT_CYCLES=8, responder never acks a read of 0x004:
  - rsp_valid with rsp_error=1, rsp_rdata=0 exactly 8 WAIT cycles after REQ;
  - err_count=1.
  - Then inject up_rack in IDLE → stray_ack=1, no rsp_valid.
- Hold rsp_ready=0 for 5 cycles after a completed read:
  - rsp_valid and rsp_rdata stable for all 5 cycles;
  - cmd_ready=0 throughout;
  - next command accepted on the cycle after the rsp handshake.
- Assert reset for 1 cycle in WAIT of a write:
  - all outputs 0 the next cycle;
  - a later up_wack sets nothing except stray_ack (which was cleared, then becomes 1);
  - the next command completes normally.
- Read command with the responder driving up_wack and up_rack in the same cycle → rsp_rdata captured, rsp_error=0, stray_ack=1.

Source files
------------

// File: rtl/axi_fsrc_up_cmd_master_if.sv
// Command/response streams plus the up_* register bus of the FSRC command master.
interface axi_fsrc_up_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [13:0] cmd_addr;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  logic        up_wreq;
  logic [13:0] up_waddr;
  logic [31:0] up_wdata;
  logic        up_wack;
  logic        up_rreq;
  logic [13:0] up_raddr;
  logic [31:0] up_rdata;
  logic        up_rack;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           up_wack, up_rdata, up_rack,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error,
           up_wreq, up_waddr, up_wdata, up_rreq, up_raddr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           up_wack, up_rdata, up_rack,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error,
           up_wreq, up_waddr, up_wdata, up_rreq, up_raddr
  );
endinterface

// File: rtl/axi_fsrc_up_cmd_master.sv
// Single-word up_* bus initiator: one bus request per command, ack wait with
// optional timeout, one response per command.
module axi_fsrc_up_cmd_master #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ERR_CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  axi_fsrc_up_cmd_master_if.master bus,
  output logic                     busy,
  output logic                     stray_ack,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RSP} state_e;

  state_e                   state_q, state_d;
  logic                     wr_q, wr_d;
  logic [13:0]              addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic                     stray_q, stray_d;
  logic [ERR_CNT_WIDTH-1:0] errcnt_q, errcnt_d;

  logic match_ack, other_ack, timeout_hit;

  assign match_ack   = wr_q ? bus.up_wack : bus.up_rack;
  assign other_ack   = wr_q ? bus.up_rack : bus.up_wack;
  // The threshold is only consulted when the timeout is enabled; the counter
  // just wraps harmlessly otherwise.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Next-state, command latch, wait counter, response capture and sticky flags.
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    stray_d  = stray_q;
    errcnt_d = errcnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          wr_d    = bus.cmd_write;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A matching ack beats a simultaneous timeout.
        if (match_ack) begin
          rdata_d = wr_q ? 32'h0 : bus.up_rdata;
          err_d   = 1'b0;
          state_d = S_RSP;
        end else if (timeout_hit) begin
          rdata_d  = 32'h0;
          err_d    = 1'b1;
          errcnt_d = (&errcnt_q) ? errcnt_q : errcnt_q + 1'b1;
          state_d  = S_RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RSP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Only a matching ack inside WAIT is legitimate; everything else is stray,
    // including late acks after a timeout and acks during REQ.
    if (state_q != S_WAIT) begin
      if (bus.up_wack || bus.up_rack) stray_d = 1'b1;
    end else if (other_ack) begin
      stray_d = 1'b1;
    end
  end

  // State and datapath registers; reset drops any in-flight command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      stray_q  <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      stray_q  <= stray_d;
      errcnt_q <= errcnt_d;
    end
  end

  logic on_bus, in_rsp;
  assign on_bus = (state_q == S_REQ) || (state_q == S_WAIT);
  assign in_rsp = (state_q == S_RSP);

  // Only the bus of the active command type carries non-zero address/data.
  assign bus.cmd_ready = (state_q == S_IDLE) && !reset;
  assign bus.up_wreq   = (state_q == S_REQ) && wr_q;
  assign bus.up_rreq   = (state_q == S_REQ) && !wr_q;
  assign bus.up_waddr  = (on_bus && wr_q)  ? addr_q  : '0;
  assign bus.up_wdata  = (on_bus && wr_q)  ? wdata_q : '0;
  assign bus.up_raddr  = (on_bus && !wr_q) ? addr_q  : '0;
  assign bus.rsp_valid = in_rsp;
  assign bus.rsp_write = in_rsp && wr_q;
  assign bus.rsp_rdata = in_rsp ? rdata_q : '0;
  assign bus.rsp_error = in_rsp && err_q;
  assign busy          = (state_q != S_IDLE);
  assign stray_ack     = stray_q;
  assign err_count     = errcnt_q;
endmodule

// File: tb/tb_axi_fsrc_up_cmd_master.sv
// Bench for axi_fsrc_up_cmd_master: registered regmap responder, memory
// reference model, timeout/stray/reset/backpressure scenarios.
module tb_axi_fsrc_up_cmd_master;
  localparam int TO  = 8;
  localparam int ECW = 2;
  localparam logic [ECW-1:0] ESAT = '1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  axi_fsrc_up_cmd_master_if bus ();
  logic           busy, stray_ack;
  logic [ECW-1:0] err_count;

  axi_fsrc_up_cmd_master #(.TIMEOUT_CYCLES(TO), .ERR_CNT_WIDTH(ECW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .busy(busy), .stray_ack(stray_ack), .err_count(err_count)
  );

  // Responder: mode 0 = ack one cycle after req, 1 = silent, 2 = both acks.
  int          mode = 0;
  logic        mem_clr = 1'b1;
  logic        pre_en = 1'b0;
  logic [5:0]  pre_a = '0;
  logic [31:0] pre_d = '0;
  logic [31:0] rmem [64];
  logic        r_wack = 1'b0, r_rack = 1'b0, inj_wack = 1'b0, inj_rack = 1'b0;
  logic [31:0] r_rdata = '0;

  assign bus.up_wack  = r_wack | inj_wack;
  assign bus.up_rack  = r_rack | inj_rack;
  assign bus.up_rdata = r_rdata;

  always @(posedge clk) begin
    r_wack <= 1'b0;
    r_rack <= 1'b0;
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) rmem[i] <= '0;
    end else if (pre_en) begin
      rmem[pre_a] <= pre_d;
    end else if (mode != 1) begin
      if (bus.up_wreq) begin
        rmem[bus.up_waddr[5:0]] <= bus.up_wdata;
        r_wack <= 1'b1;
        if (mode == 2) r_rack <= 1'b1;
      end
      if (bus.up_rreq) begin
        r_rack  <= 1'b1;
        r_rdata <= rmem[bus.up_raddr[5:0]];
        if (mode == 2) r_wack <= 1'b1;
      end
    end
  end

  // Reference model: plain memory image plus expected timeout total.
  logic [31:0] exp_mem [64];
  int          exp_to = 0;

  int total = 0, bad = 0;

  // Observations of the last command.
  int          lat, nw, nr, unst, wrdy;
  logic [13:0] oa;
  logic [31:0] owd, ord;
  logic        ow, oe;

  function automatic logic any_out();
    return |{bus.cmd_ready, bus.rsp_valid, bus.rsp_write, bus.rsp_rdata, bus.rsp_error,
             bus.up_wreq, bus.up_waddr, bus.up_wdata, bus.up_rreq, bus.up_raddr,
             busy, stray_ack, err_count};
  endfunction

  // Issue one command from a negedge; ends on the negedge after the rsp handshake.
  task automatic run(input bit wr, input logic [13:0] a, input logic [31:0] d, input int hold);
    wrdy = 0;
    while (!bus.cmd_ready && wrdy < 20) begin @(negedge clk); wrdy++; end
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_wdata = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_write = $urandom_range(0, 1);
    bus.cmd_addr = 14'($urandom); bus.cmd_wdata = $urandom;
    lat = -1; nw = 0; nr = 0; unst = 0; oa = '0; owd = '0; ow = 1'b0; ord = '0; oe = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 1) begin oa = wr ? bus.up_waddr : bus.up_raddr; owd = bus.up_wdata; end
      nw += int'(bus.up_wreq);
      nr += int'(bus.up_rreq);
      if (bus.rsp_valid) begin lat = k; break; end
      @(negedge clk);
    end
    if (lat < 0) return;
    ow = bus.rsp_write; ord = bus.rsp_rdata; oe = bus.rsp_error;
    if (bus.cmd_ready !== 1'b0) unst++;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== ord || bus.rsp_write !== ow ||
          bus.rsp_error !== oe || bus.cmd_ready !== 1'b0) unst++;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    mem_clr = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (any_out() !== 1'b0) begin bad++; $display("FAIL reset_outs: some output nonzero, need all 0"); end
    reset = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    total++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || stray_ack !== 1'b0 || err_count !== '0) begin
      bad++; $display("FAIL idle_after_reset: rdy=%b busy=%b stray=%b err=%0d, need 1 0 0 0",
                      bus.cmd_ready, busy, stray_ack, err_count);
    end
  endtask

  task automatic test_write_read();
    run(1'b1, 14'h002, 32'hDEADBEEF, 0);
    exp_mem[2] = 32'hDEADBEEF;
    total++;
    if (lat !== 3 || nw !== 1 || nr !== 0 || oa !== 14'h002 || owd !== 32'hDEADBEEF) begin
      bad++; $display("FAIL write_req: lat=%0d wreq=%0d rreq=%0d addr=%h data=%h, need 3 1 0 002 deadbeef",
                      lat, nw, nr, oa, owd);
    end
    total++;
    if (ow !== 1'b1 || oe !== 1'b0 || ord !== 32'h0) begin
      bad++; $display("FAIL write_rsp: w=%b e=%b rd=%h, need 1 0 0", ow, oe, ord);
    end
    run(1'b0, 14'h002, 32'h0, 0);
    total++;
    if (lat !== 3 || nr !== 1 || nw !== 0 || oa !== 14'h002 || ow !== 1'b0 || oe !== 1'b0 || ord !== exp_mem[2]) begin
      bad++; $display("FAIL read_back: lat=%0d rreq=%0d addr=%h w=%b e=%b rd=%h, need 3 1 002 0 0 %h",
                      lat, nr, oa, ow, oe, ord, exp_mem[2]);
    end
  endtask

  task automatic test_read_const();
    pre_en = 1'b1; pre_a = 6'd3; pre_d = 32'h46535243;
    @(negedge clk);
    pre_en = 1'b0;
    exp_mem[3] = 32'h46535243;
    run(1'b0, 14'h003, 32'h0, 0);
    total++;
    if (ord !== exp_mem[3] || oe !== 1'b0 || err_count !== '0 || stray_ack !== 1'b0) begin
      bad++; $display("FAIL read_const: rd=%h e=%b err=%0d stray=%b, need %h 0 0 0",
                      ord, oe, err_count, stray_ack, exp_mem[3]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      bit          wr;
      logic [5:0]  a;
      logic [31:0] d, er;
      wr = 1'($urandom_range(0, 1));
      a  = 6'($urandom_range(0, 63));
      d  = $urandom;
      er = wr ? 32'h0 : exp_mem[a];
      run(wr, {8'h0, a}, d, $urandom_range(0, 2));
      if (wr) exp_mem[a] = d;
      total++;
      if (lat !== 3 || ow !== wr || oe !== 1'b0 || ord !== er || unst !== 0 ||
          nw !== int'(wr) || nr !== int'(!wr) || oa !== {8'h0, a}) begin
        bad++; $display("FAIL random[%0d]: lat=%0d w=%b e=%b rd=%h unst=%0d addr=%h, need 3 %b 0 %h 0 %h",
                        i, lat, ow, oe, ord, unst, oa, wr, er, a);
      end
    end
  endtask

  task automatic test_backpressure();
    run(1'b0, 14'h002, 32'h0, 5);
    total++;
    if (unst !== 0 || ord !== exp_mem[2]) begin
      bad++; $display("FAIL rsp_hold: unstable=%0d rd=%h, need 0 %h", unst, ord, exp_mem[2]);
    end
    run(1'b1, 14'h006, 32'h12345678, 0);
    exp_mem[6] = 32'h12345678;
    total++;
    if (wrdy !== 0 || lat !== 3) begin
      bad++; $display("FAIL accept_after_rsp: wait=%0d lat=%0d, need 0 3", wrdy, lat);
    end
  endtask

  task automatic test_timeout();
    mode = 1;
    run(1'b0, 14'h004, 32'h0, 0);
    exp_to++;
    total++;
    if (lat !== TO + 2 || oe !== 1'b1 || ord !== 32'h0 || nr !== 1 || err_count !== ECW'(exp_to) || stray_ack !== 1'b0) begin
      bad++; $display("FAIL timeout: lat=%0d e=%b rd=%h rreq=%0d err=%0d stray=%b, need %0d 1 0 1 %0d 0",
                      lat, oe, ord, nr, err_count, stray_ack, TO + 2, exp_to);
    end
    mode = 0;
    inj_rack = 1'b1;
    @(negedge clk);
    inj_rack = 1'b0;
    total++;
    if (stray_ack !== 1'b1 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_stray: stray=%b rsp_valid=%b busy=%b, need 1 0 0", stray_ack, bus.rsp_valid, busy);
    end
  endtask

  task automatic test_err_saturate();
    mode = 1;
    for (int i = 0; i < 3; i++) begin
      logic [ECW-1:0] ec;
      run(1'b1, 14'h009, $urandom, 0);
      exp_to++;
      ec = (exp_to >= int'(ESAT)) ? ESAT : ECW'(exp_to);
      total++;
      if (err_count !== ec || oe !== 1'b1 || ow !== 1'b1 || ord !== 32'h0) begin
        bad++; $display("FAIL err_sat[%0d]: err=%0d e=%b w=%b rd=%h, need %0d 1 1 0", i, err_count, oe, ow, ord, ec);
      end
    end
    mode = 0;
  endtask

  task automatic test_reset_in_wait();
    mode = 1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 14'h007; bus.cmd_wdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || bus.up_waddr !== 14'h007 || bus.up_wreq !== 1'b0) begin
      bad++; $display("FAIL wait_state: busy=%b waddr=%h wreq=%b, need 1 007 0", busy, bus.up_waddr, bus.up_wreq);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (any_out() !== 1'b0) begin bad++; $display("FAIL reset_in_wait: some output nonzero, need all 0"); end
    reset = 1'b0;
    exp_to = 0;
    inj_wack = 1'b1;
    @(negedge clk);
    inj_wack = 1'b0;
    total++;
    if (stray_ack !== 1'b1 || bus.rsp_valid !== 1'b0 || busy !== 1'b0 || err_count !== '0) begin
      bad++; $display("FAIL late_wack: stray=%b rsp_valid=%b busy=%b err=%0d, need 1 0 0 0",
                      stray_ack, bus.rsp_valid, busy, err_count);
    end
    mode = 0;
    run(1'b1, 14'h007, 32'h0BADF00D, 0);
    exp_mem[7] = 32'h0BADF00D;
    run(1'b0, 14'h007, 32'h0, 0);
    total++;
    if (lat !== 3 || oe !== 1'b0 || ord !== exp_mem[7]) begin
      bad++; $display("FAIL post_reset_cmd: lat=%0d e=%b rd=%h, need 3 0 %h", lat, oe, ord, exp_mem[7]);
    end
  endtask

  task automatic test_both_acks();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (stray_ack !== 1'b0) begin bad++; $display("FAIL stray_cleared: stray=%b, need 0", stray_ack); end
    mode = 2;
    run(1'b0, 14'h002, 32'h0, 0);
    mode = 0;
    total++;
    if (lat !== 3 || oe !== 1'b0 || ord !== exp_mem[2] || stray_ack !== 1'b1) begin
      bad++; $display("FAIL both_acks: lat=%0d e=%b rd=%h stray=%b, need 3 0 %h 1", lat, oe, ord, stray_ack, exp_mem[2]);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 64; i++) exp_mem[i] = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_read_const();
    test_random();
    test_backpressure();
    test_timeout();
    test_err_saturate();
    test_reset_in_wait();
    test_both_acks();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, need completion");
    $fatal(1);
  end
endmodule
